// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase response multiplexer with built-in default slave.
// Address-phase selects are registered on HREADY; the selected slave's
// response is forwarded combinationally during the data phase. Unmapped
// active transfers are answered with a two-cycle ERROR by the default slave.
module ahblite_slave_mux #(
  parameter bit P0_EN = 1'b1,
  parameter bit P1_EN = 1'b1,
  parameter bit P2_EN = 1'b1,
  parameter bit P3_EN = 1'b1,
  parameter bit P4_EN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic [31:0] P0_HRDATA,
  input  logic        P0_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HSEL,
  input  logic [31:0] P1_HRDATA,
  input  logic        P1_HREADYOUT,
  input  logic        P1_HRESP,
  input  logic        P2_HSEL,
  input  logic [31:0] P2_HRDATA,
  input  logic        P2_HREADYOUT,
  input  logic        P2_HRESP,
  input  logic        P3_HSEL,
  input  logic [31:0] P3_HRDATA,
  input  logic        P3_HREADYOUT,
  input  logic        P3_HRESP,
  input  logic        P4_HSEL,
  input  logic [31:0] P4_HRDATA,
  input  logic        P4_HREADYOUT,
  input  logic        P4_HRESP,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [7:0]  ERR_CNT
);

  // One-hot data-phase owner
  typedef enum logic [6:0] {
    SEL_NONE = 7'b0000001,
    SEL_P0   = 7'b0000010,
    SEL_P1   = 7'b0000100,
    SEL_P2   = 7'b0001000,
    SEL_P3   = 7'b0010000,
    SEL_P4   = 7'b0100000,
    SEL_DEF  = 7'b1000000
  } sel_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_t;

  logic [4:0] en_sel;
  logic       trans_active;
  sel_t       sel_d;
  sel_t       sel_q;
  logic       def_hit;
  ds_t        ds_q;
  ds_t        ds_d;
  logic       ds_ready;
  logic       ds_resp;
  logic       err_inc;

  assign en_sel = {P4_HSEL & P4_EN, P3_HSEL & P3_EN, P2_HSEL & P2_EN,
                   P1_HSEL & P1_EN, P0_HSEL & P0_EN};

  // NONSEQ or SEQ
  assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // Address-phase decode: lowest enabled port wins, else default slave or none
  always_comb begin
    sel_d = SEL_NONE;
    if      (en_sel[0])    sel_d = SEL_P0;
    else if (en_sel[1])    sel_d = SEL_P1;
    else if (en_sel[2])    sel_d = SEL_P2;
    else if (en_sel[3])    sel_d = SEL_P3;
    else if (en_sel[4])    sel_d = SEL_P4;
    else if (trans_active) sel_d = SEL_DEF;
  end

  assign def_hit = (sel_d == SEL_DEF);

  // Data-phase owner register, advances only when the bus is ready
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= SEL_NONE;
    else if (HREADY) sel_q <= sel_d;
  end

  // Default-slave state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_q <= DS_IDLE;
    else          ds_q <= ds_d;
  end

  // Default-slave next state and two-cycle ERROR response
  always_comb begin
    ds_d     = ds_q;
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    err_inc  = 1'b0;
    unique case (ds_q)
      DS_IDLE: begin
        if (HREADY && def_hit) begin
          ds_d    = DS_ERR1;
          err_inc = 1'b1;
        end
      end
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
        ds_d     = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = 1'b1;
        if (HREADY && def_hit) begin
          ds_d    = DS_ERR1;
          err_inc = 1'b1;
        end else begin
          ds_d = DS_IDLE;
        end
      end
      default: ds_d = DS_IDLE;
    endcase
  end

  // Saturating default-slave hit counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                        ERR_CNT <= '0;
    else if (err_inc && ERR_CNT != '1)   ERR_CNT <= ERR_CNT + 8'd1;
  end

  // Response mux from the registered data-phase owner
  always_comb begin
    HRDATA    = '0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (sel_q)
      SEL_P0:  begin HRDATA = P0_HRDATA; HREADYOUT = P0_HREADYOUT; HRESP = P0_HRESP; end
      SEL_P1:  begin HRDATA = P1_HRDATA; HREADYOUT = P1_HREADYOUT; HRESP = P1_HRESP; end
      SEL_P2:  begin HRDATA = P2_HRDATA; HREADYOUT = P2_HREADYOUT; HRESP = P2_HRESP; end
      SEL_P3:  begin HRDATA = P3_HRDATA; HREADYOUT = P3_HREADYOUT; HRESP = P3_HRESP; end
      SEL_P4:  begin HRDATA = P4_HRDATA; HREADYOUT = P4_HREADYOUT; HRESP = P4_HRESP; end
      SEL_DEF: begin HREADYOUT = ds_ready; HRESP = ds_resp; end
      default: ;
    endcase
  end

endmodule
